switch_allocator: RTL and testbench

- Per-output packet-locking switch allocator for the mesh router.
- Each of the CHANNEL_NUMBER inputs presents the output port it needs, taken from routing, plus the packet length from its header flit.
- Each output runs its own round-robin arbitration among header requests, locks the winner for the whole packet, and releases after the last flit.
- Drives the select lines of the per-output AXI-Stream muxes and the per-input ready gating.

---
 rtl/switch_allocator.sv | 180 ++++++++++++++++++
 tb/tb_switch_allocator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Per-output packet-locking round-robin switch allocator for the mesh router.
// Optional watchdog release of stalled locks: define ALLOC_TIMEOUT_EN.
module switch_allocator_lane #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int LEN_WIDTH            = 8,
`ifdef ALLOC_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES       = 255,
`endif
  parameter int OUT_IDX              = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [CHANNEL_NUMBER-1:0]                req_valid,
  input  logic [CHANNEL_NUMBER-1:0]                req_is_header,
  input  logic [CHANNEL_NUMBER*CHANNEL_NUMBER_WIDTH-1:0] req_port,
  input  logic [CHANNEL_NUMBER*LEN_WIDTH-1:0]      req_len,
  input  logic [CHANNEL_NUMBER-1:0]                in_granted,
  input  logic                                     out_fire,
  output logic                                     grant_valid,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]          grant_sel
`ifdef ALLOC_TIMEOUT_EN
  ,output logic                                    timeout_err
`endif
);
  localparam int N = CHANNEL_NUMBER;
  localparam int W = CHANNEL_NUMBER_WIDTH;
  localparam logic [W-1:0] MY_PORT = W'(OUT_IDX);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state;
  logic [W-1:0]         ptr;
  logic [LEN_WIDTH-1:0] rem;
  logic [N-1:0]         elig;
  logic                 found;
  logic [W-1:0]         winner;
  logic [W:0]           idx;
  logic [LEN_WIDTH-1:0] win_len;
  logic [W-1:0]         nxt_ptr;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++)
      elig[i] = req_valid[i] & req_is_header[i] & ~in_granted[i] &
                (req_port[i*W +: W] == MY_PORT);
  end

  // search from ptr, wrapping modulo N (N need not be a power of two)
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (W+1)'(k);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!found && elig[idx[W-1:0]]) begin
        found  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

  assign win_len     = req_len[winner*LEN_WIDTH +: LEN_WIDTH];
  assign nxt_ptr     = (grant_sel == W'(N-1)) ? '0 : grant_sel + W'(1);
  assign grant_valid = (state == LOCKED);

`ifdef ALLOC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall;
  wire           stall_hit = (stall == SW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                           stall <= '0;
    else if (state != LOCKED || out_fire) stall <= '0;
    else if (!stall_hit)                  stall <= stall + SW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_sel <= '0;
      rem       <= '0;
      ptr       <= '0;
`ifdef ALLOC_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ALLOC_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE:
          if (found) begin
            state     <= LOCKED;
            grant_sel <= winner;
            rem       <= (win_len == '0) ? LEN_WIDTH'(1) : win_len;
          end
        LOCKED:
          if (out_fire) begin
            if (rem == LEN_WIDTH'(1)) begin
              state <= IDLE;
              ptr   <= nxt_ptr;
            end else begin
              rem <= rem - LEN_WIDTH'(1);
            end
          end
`ifdef ALLOC_TIMEOUT_EN
          else if (stall_hit) begin
            state       <= IDLE;
            ptr         <= nxt_ptr;
            timeout_err <= 1'b1;
          end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module switch_allocator #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int LEN_WIDTH            = 8,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [CHANNEL_NUMBER-1:0]                      req_valid,
  input  logic [CHANNEL_NUMBER-1:0]                      req_is_header,
  input  logic [CHANNEL_NUMBER*CHANNEL_NUMBER_WIDTH-1:0] req_port,
  input  logic [CHANNEL_NUMBER*LEN_WIDTH-1:0]            req_len,
  input  logic [CHANNEL_NUMBER-1:0]                      out_fire,
  output logic [CHANNEL_NUMBER-1:0]                      grant_valid,
  output logic [CHANNEL_NUMBER*CHANNEL_NUMBER_WIDTH-1:0] grant_sel,
  output logic [CHANNEL_NUMBER-1:0]                      in_granted
`ifdef ALLOC_TIMEOUT_EN
  ,output logic [CHANNEL_NUMBER-1:0]                     timeout_err
`endif
);
  localparam int N = CHANNEL_NUMBER;
  localparam int W = CHANNEL_NUMBER_WIDTH;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // derived purely from lock registers, so it cannot loop back through eligibility
  always_comb begin
    in_granted = '0;
    for (int o = 0; o < N; o++)
      if (grant_valid[o]) in_granted[grant_sel[o*W +: W]] = 1'b1;
  end

  for (genvar o = 0; o < N; o++) begin : g_out
    switch_allocator_lane #(
      .CHANNEL_NUMBER       (N),
      .CHANNEL_NUMBER_WIDTH (W),
      .LEN_WIDTH            (LEN_WIDTH),
`ifdef ALLOC_TIMEOUT_EN
      .TIMEOUT_CYCLES       (TIMEOUT_CYCLES),
`endif
      .OUT_IDX              (o)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_is_header (req_is_header),
      .req_port      (req_port),
      .req_len       (req_len),
      .in_granted    (in_granted),
      .out_fire      (out_fire[o]),
      .grant_valid   (grant_valid[o]),
      .grant_sel     (grant_sel[o*W +: W])
`ifdef ALLOC_TIMEOUT_EN
      ,.timeout_err  (timeout_err[o])
`endif
    );
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Randomized and directed bench for switch_allocator against a packet-level
// reference model (per-output lock owner, flits remaining, round-robin pointer).
module tb_switch_allocator;
  localparam int N  = 5;
  localparam int W  = $clog2(N);
  localparam int LW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid, req_is_header, out_fire;
  logic [N*W-1:0]  req_port;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    grant_valid, in_granted;
  logic [N*W-1:0]  grant_sel;
`ifdef ALLOC_TIMEOUT_EN
  logic [N-1:0]    timeout_err;
`endif

  switch_allocator #(
    .CHANNEL_NUMBER (N), .CHANNEL_NUMBER_WIDTH (W), .LEN_WIDTH (LW), .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_is_header (req_is_header),
    .req_port (req_port), .req_len (req_len), .out_fire (out_fire),
    .grant_valid (grant_valid), .grant_sel (grant_sel), .in_granted (in_granted)
`ifdef ALLOC_TIMEOUT_EN
    ,.timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int m_lock[N], m_owner[N], m_rem[N], m_ptr[N], m_stall[N], m_err[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_rem[o] = 0; m_ptr[o] = 0; m_stall[o] = 0; m_err[o] = 0;
    end
  endtask

  // next state of every output from the inputs seen at the coming edge
  task automatic model_step();
    int busy[N];
    for (int i = 0; i < N; i++) busy[i] = 0;
    for (int o = 0; o < N; o++) if (m_lock[o] != 0) busy[m_owner[o]] = 1;
    for (int o = 0; o < N; o++) begin
      m_err[o] = 0;
      if (m_lock[o] != 0) begin
        if (out_fire[o]) begin
          m_stall[o] = 0;
          if (m_rem[o] == 1) begin m_lock[o] = 0; m_ptr[o] = (m_owner[o] + 1) % N; end
          else m_rem[o] = m_rem[o] - 1;
        end else begin
`ifdef ALLOC_TIMEOUT_EN
          if (m_stall[o] == TO) begin
            m_lock[o] = 0; m_ptr[o] = (m_owner[o] + 1) % N; m_err[o] = 1;
          end else m_stall[o] = m_stall[o] + 1;
`endif
        end
      end else begin
        m_stall[o] = 0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (req_valid[i] && req_is_header[i] && int'(req_port[i*W +: W]) == o && busy[i] == 0) begin
            m_lock[o]  = 1;
            m_owner[o] = i;
            m_rem[o]   = (req_len[i*LW +: LW] == 0) ? 1 : int'(req_len[i*LW +: LW]);
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]   e_gv, e_ing;
    logic [N*W-1:0] e_sel, mask;
    e_gv = '0; e_ing = '0; e_sel = '0; mask = '0;
    for (int o = 0; o < N; o++)
      if (m_lock[o] != 0) begin
        e_gv[o] = 1'b1;
        e_sel[o*W +: W] = W'(m_owner[o]);
        mask[o*W +: W]  = '1;
        e_ing[m_owner[o]] = 1'b1;
      end
    check("grant_valid", 64'(grant_valid), 64'(e_gv));
    check("grant_sel", 64'(grant_sel & mask), 64'(e_sel));
    check("in_granted", 64'(in_granted), 64'(e_ing));
`ifdef ALLOC_TIMEOUT_EN
    begin
      logic [N-1:0] e_err;
      for (int o = 0; o < N; o++) e_err[o] = (m_err[o] != 0);
      check("timeout_err", 64'(timeout_err), 64'(e_err));
    end
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_req();
    req_valid = '0; req_is_header = '0; req_port = '0; req_len = '0;
  endtask

  task automatic set_req(input int i, input int port, input int len);
    req_valid[i] = 1'b1; req_is_header[i] = 1'b1;
    req_port[i*W +: W] = W'(port); req_len[i*LW +: LW] = LW'(len);
  endtask

  function automatic int sel_of(input int o);
    return int'(grant_sel[o*W +: W]);
  endfunction

  initial begin
    int order[$];
    int pulses;
    rst_n = 1'b0; clear_req(); out_fire = '0;
    model_reset();
    #1;
    check("reset grant_valid", 64'(grant_valid), 64'(0));
    check("reset grant_sel", 64'(grant_sel), 64'(0));
    check("reset in_granted", 64'(in_granted), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // single packet: input 2 -> output 4, 3 flits
    set_req(2, 4, 3);
    cycle();
    check("single gv4", 64'(grant_valid[4]), 64'(1));
    check("single sel4", 64'(sel_of(4)), 64'(2));
    check("single ing2", 64'(in_granted[2]), 64'(1));
    clear_req(); out_fire[4] = 1'b1;
    cycle(); cycle();
    check("single held", 64'(grant_valid[4]), 64'(1));
    cycle();
    check("single release", 64'(grant_valid[4]), 64'(0));
    check("single ing2 drop", 64'(in_granted[2]), 64'(0));
    out_fire = '0;

    // contention on output 1, fire always high
    set_req(0, 1, 1); set_req(1, 1, 1); set_req(3, 1, 1);
    out_fire[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (grant_valid[1]) order.push_back(sel_of(1));
    end
    check("rr count", 64'(order.size()), 64'(4));
    check("rr order", {order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1},
          {32'd0, 32'd1});
    check("rr order tail", {order.size() > 2 ? order[2] : -1, order.size() > 3 ? order[3] : -1},
          {32'd3, 32'd0});
    clear_req(); out_fire = '0;
    cycle(); cycle();

    // wrap: drive output 0 pointer to 4, then inputs 0 and 4 contend
    out_fire[0] = 1'b1;
    set_req(3, 0, 1);
    cycle();
    clear_req();
    cycle();
    set_req(0, 0, 1); set_req(4, 0, 1);
    cycle();
    check("wrap first", 64'(sel_of(0)), 64'(4));
    cycle();
    cycle();
    check("wrap second", 64'(sel_of(0)), 64'(0));
    clear_req(); cycle(); out_fire = '0;

    // parallel outputs with independent lengths
    set_req(0, 2, 2); set_req(1, 3, 3);
    cycle();
    check("par gv", 64'(grant_valid[3:2]), 64'(2'b11));
    check("par sel", {sel_of(2), sel_of(3)}, {32'd0, 32'd1});
    clear_req(); out_fire[2] = 1'b1; out_fire[3] = 1'b1;
    cycle(); cycle();
    check("par split", 64'(grant_valid[3:2]), 64'(2'b10));
    cycle();
    check("par done", 64'(grant_valid[3:2]), 64'(2'b00));
    out_fire = '0;

    // length 0 behaves as a single flit
    set_req(2, 0, 0);
    cycle();
    check("len0 gv", 64'(grant_valid[0]), 64'(1));
    clear_req(); out_fire[0] = 1'b1;
    cycle();
    check("len0 release", 64'(grant_valid[0]), 64'(0));
    out_fire = '0;

    // body flit never starts a grant; port 7 matches nothing
    set_req(1, 0, 2); req_is_header[1] = 1'b0;
    cycle(); cycle();
    check("nonheader", 64'(grant_valid), 64'(0));
    set_req(1, 7, 2);
    cycle(); cycle();
    check("port7", 64'(grant_valid), 64'(0));
    clear_req();

    // stalled lock with no fire
    set_req(3, 0, 5);
    cycle();
    clear_req();
    pulses = 0;
    for (int c = 0; c < 1100; c++) begin
      cycle();
`ifdef ALLOC_TIMEOUT_EN
      if (timeout_err[0]) pulses++;
`endif
    end
`ifdef ALLOC_TIMEOUT_EN
    check("timeout pulses", 64'(pulses), 64'(1));
    check("timeout released", 64'(grant_valid[0]), 64'(0));
`else
    check("lock persists", 64'(grant_valid[0]), 64'(1));
    check("lock owner", 64'(sel_of(0)), 64'(3));
`endif

    // reset mid-packet takes effect without a clock edge
    set_req(2, 1, 4);
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset gv", 64'(grant_valid), 64'(0));
    check("midreset sel", 64'(grant_sel), 64'(0));
    check("midreset ing", 64'(in_granted), 64'(0));
    clear_req();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]        = ($urandom_range(0, 9) < 6);
        req_is_header[i]    = ($urandom_range(0, 9) < 3);
        req_port[i*W +: W]  = W'($urandom_range(0, 7));
        req_len[i*LW +: LW] = LW'($urandom_range(0, 4));
        out_fire[i]         = ($urandom_range(0, 1) == 1);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
